fwd_select_ctrl: RTL and testbench

// - Generates the registered 2-bit select codes for the two 32-bit 4:1 EX-stage operand muxes (sel 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 WB bypass).
// - Sits between ID/RR issue and EX. Tracks the destination tags of the three in-flight older instructions (EX, MEM, WB) and stalls issue on load-use.

---
 rtl/fwd_select_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_fwd_select_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fwd_select_ctrl.sv
// ----------------------------------------------------------------------------
// fwd_select_ctrl
// Produces the registered 2-bit select codes for the two EX-stage 4:1 operand
// muxes and stalls issue on a load-use hazard.
//   sel code: 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 WB bypass
// The destination tags of the three older in-flight instructions are kept in
// slots s1 (EX), s2 (MEM) and s3 (WB). The slots advance on every clock edge.
// On each edge s1 loads either the issuing instruction or a bubble.
//
// Optional feature: define FWD_PERF_CNT_EN to build a saturating load-use
// stall counter. Without it stall_cnt is tied to zero and no counter flops
// exist.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   id_valid          ID stage presents an instruction
//   id_rs1, id_rs2    source registers of the ID instruction
//   id_rd             destination register of the ID instruction
//   id_reg_write      ID instruction writes id_rd
//   id_is_load        ID instruction is a load
//   flush             squash the ID instruction this cycle
//   id_ready          combinational accept of the ID instruction
//   ex_valid          registered, EX holds a real instruction
//   sel_a, sel_b      registered operand mux selects for the EX instruction
//   stall_cnt         registered load-use stall count (zero when disabled)
// ----------------------------------------------------------------------------
module fwd_select_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              flush,
    output logic              id_ready,
    output logic              ex_valid,
    output logic [1:0]        sel_a,
    output logic [1:0]        sel_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

    // Only s1 needs the load flag: a load that has reached MEM/WB can forward.
    logic              s1_vld_r, s1_wr_r, s1_ld_r;
    logic [REG_AW-1:0] s1_rd_r;
    logic              s2_vld_r, s2_wr_r;
    logic [REG_AW-1:0] s2_rd_r;
    logic              s3_vld_r, s3_wr_r;
    logic [REG_AW-1:0] s3_rd_r;

    logic              ex_valid_r;
    logic [1:0]        sel_a_r, sel_b_r;
    logic              load_use_s;
    logic              issue_s;
    logic [1:0]        sel_a_s, sel_b_s;

    // A slot forwards to a source only if it really writes that register;
    // x0 is constant zero and never forwarded.
    function automatic logic wr_match(input logic vld, input logic wr,
                                      input logic [REG_AW-1:0] rd,
                                      input logic [REG_AW-1:0] rs);
        return vld & wr & (rd == rs) & (rs != REG_ZERO);
    endfunction

    // Youngest producer wins: EX/MEM over MEM/WB over WB bypass.
    function automatic logic [1:0] pick_sel(input logic m1, input logic m2,
                                            input logic m3);
        logic [1:0] s;
        if (m1) begin
            s = 2'b01;
        end else if (m2) begin
            s = 2'b10;
        end else if (m3) begin
            s = 2'b11;
        end else begin
            s = 2'b00;
        end
        return s;
    endfunction

    // Hazard detection and issue handshake; both sources are checked even if
    // the instruction does not use them.
    always_comb begin
        load_use_s = id_valid & s1_vld_r & s1_wr_r & s1_ld_r & (s1_rd_r != REG_ZERO) &
                     ((s1_rd_r == id_rs1) | (s1_rd_r == id_rs2));
        id_ready   = ~load_use_s & ~flush;
        issue_s    = id_valid & id_ready;
    end

    // Next-cycle operand selects; bubbles always select the register file.
    always_comb begin
        sel_a_s = 2'b00;
        sel_b_s = 2'b00;
        if (issue_s) begin
            sel_a_s = pick_sel(wr_match(s1_vld_r, s1_wr_r, s1_rd_r, id_rs1),
                               wr_match(s2_vld_r, s2_wr_r, s2_rd_r, id_rs1),
                               wr_match(s3_vld_r, s3_wr_r, s3_rd_r, id_rs1));
            sel_b_s = pick_sel(wr_match(s1_vld_r, s1_wr_r, s1_rd_r, id_rs2),
                               wr_match(s2_vld_r, s2_wr_r, s2_rd_r, id_rs2),
                               wr_match(s3_vld_r, s3_wr_r, s3_rd_r, id_rs2));
        end else begin
            sel_a_s = 2'b00;
            sel_b_s = 2'b00;
        end
    end

    // Pipeline tag slots: older instructions always advance, s1 takes the
    // issuing instruction or a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_r <= 1'b0;
            s1_wr_r  <= 1'b0;
            s1_ld_r  <= 1'b0;
            s1_rd_r  <= REG_ZERO;
            s2_vld_r <= 1'b0;
            s2_wr_r  <= 1'b0;
            s2_rd_r  <= REG_ZERO;
            s3_vld_r <= 1'b0;
            s3_wr_r  <= 1'b0;
            s3_rd_r  <= REG_ZERO;
        end else begin
            s3_vld_r <= s2_vld_r;
            s3_wr_r  <= s2_wr_r;
            s3_rd_r  <= s2_rd_r;
            s2_vld_r <= s1_vld_r;
            s2_wr_r  <= s1_wr_r;
            s2_rd_r  <= s1_rd_r;
            if (issue_s) begin
                s1_vld_r <= 1'b1;
                s1_wr_r  <= id_reg_write;
                s1_ld_r  <= id_is_load;
                s1_rd_r  <= id_rd;
            end else begin
                s1_vld_r <= 1'b0;
                s1_wr_r  <= 1'b0;
                s1_ld_r  <= 1'b0;
                s1_rd_r  <= REG_ZERO;
            end
        end
    end

    // Registered EX-stage outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_r <= 1'b0;
            sel_a_r    <= 2'b00;
            sel_b_r    <= 2'b00;
        end else begin
            ex_valid_r <= issue_s;
            sel_a_r    <= sel_a_s;
            sel_b_r    <= sel_b_s;
        end
    end

    assign ex_valid = ex_valid_r;
    assign sel_a    = sel_a_r;
    assign sel_b    = sel_b_r;

`ifdef FWD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             stall_evt_s;
    logic [CNT_W-1:0] stall_cnt_r;

    // A flushed cycle is not a stall even if the hazard is present.
    assign stall_evt_s = id_valid & load_use_s & ~flush;

    // Saturating stall counter, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_evt_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fwd_select_ctrl.sv
module tb_fwd_select_ctrl;

`ifdef FWD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
    logic       id_reg_write = 1'b0, id_is_load = 1'b0, flush = 1'b0;
    logic       id_ready, ex_valid, id_ready4, ex_valid4;
    logic [1:0] sel_a, sel_b, sel_a4, sel_b4;
    logic [15:0] stall_cnt;
    logic [3:0]  stall_cnt4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fwd_select_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush),
        .id_ready(id_ready), .ex_valid(ex_valid), .sel_a(sel_a), .sel_b(sel_b),
        .stall_cnt(stall_cnt)
    );

    fwd_select_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush),
        .id_ready(id_ready4), .ex_valid(ex_valid4), .sel_a(sel_a4), .sel_b(sel_b4),
        .stall_cnt(stall_cnt4)
    );

    // Reference: history of what entered EX on each of the last three edges,
    // index 0 = most recent.
    typedef struct packed {
        logic       vld;
        logic       wr;
        logic       ld;
        logic [4:0] rd;
    } slot_t;

    slot_t       hist[$];
    int unsigned m_cnt, m_cnt4;

    typedef struct {
        logic v; logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rd;
        logic wr; logic ld; logic fl;
        logic e_rdy; logic e_exv; logic [1:0] e_sa; logic [1:0] e_sb;
    } vec_t;

    vec_t tbl[27];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back(slot_t'(8'd0));
        m_cnt  = 0;
        m_cnt4 = 0;
    endtask

    // Code = 1 + age of the youngest writer of rs, 0 if none.
    function automatic logic [1:0] model_sel(input logic [4:0] rs);
        for (int i = 0; i < 3; i++) begin
            if (hist[i].vld && hist[i].wr && hist[i].rd == rs && rs != 5'd0) return 2'(i + 1);
        end
        return 2'b00;
    endfunction

    task automatic run_cycle(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic wr, input logic ld,
                             input logic fl, input logic tbl_en, input logic t_rdy,
                             input logic t_exv, input logic [1:0] t_sa, input logic [1:0] t_sb);
        logic lu, rdy, iss;
        logic [1:0] sa, sb;
        slot_t ns;
        @(negedge clk);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_reg_write = wr; id_is_load = ld; flush = fl;
        #1;
        lu  = v && hist[0].vld && hist[0].wr && hist[0].ld && hist[0].rd != 5'd0 &&
              (hist[0].rd == rs1 || hist[0].rd == rs2);
        rdy = !lu && !fl;
        iss = v && rdy;
        chk("id_ready", 32'(id_ready), 32'(rdy));
        chk("id_ready_w4", 32'(id_ready4), 32'(rdy));
        if (tbl_en) chk("tbl_id_ready", 32'(id_ready), 32'(t_rdy));
        sa = iss ? model_sel(rs1) : 2'b00;
        sb = iss ? model_sel(rs2) : 2'b00;
        if (v && lu && !fl) begin
            if (m_cnt < 32'd65535) m_cnt++;
            if (m_cnt4 < 32'd15) m_cnt4++;
        end
        if (iss) ns = '{1'b1, wr, ld, rd};
        else     ns = slot_t'(8'd0);
        hist.push_front(ns);
        void'(hist.pop_back());
        @(posedge clk);
        #1;
        chk("ex_valid", 32'(ex_valid), 32'(iss));
        chk("sel_a", 32'(sel_a), 32'(sa));
        chk("sel_b", 32'(sel_b), 32'(sb));
        chk("stall_cnt", 32'(stall_cnt), PERF ? m_cnt : 32'd0);
        chk("stall_cnt_w4", 32'(stall_cnt4), PERF ? m_cnt4 : 32'd0);
        chk("w4_match", {28'd0, ex_valid4, sel_a4, sel_b4}, {28'd0, iss, sa, sb});
        if (tbl_en) begin
            chk("tbl_ex_valid", 32'(ex_valid), 32'(t_exv));
            chk("tbl_sel_a", 32'(sel_a), 32'(t_sa));
            chk("tbl_sel_b", 32'(sel_b), 32'(t_sb));
        end
    endtask

    initial begin
        // Directed rows: v rs1 rs2 rd wr ld fl | ready ex_valid sel_a sel_b
        tbl[0]  = '{1'b1, 5'd1,  5'd2, 5'd5,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0};
        tbl[1]  = '{1'b1, 5'd5,  5'd6, 5'd8,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 2'd0};
        tbl[2]  = '{1'b1, 5'd1,  5'd2, 5'd9,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0};
        tbl[3]  = '{1'b1, 5'd8,  5'd0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 2'd0};
        tbl[4]  = '{1'b1, 5'd8,  5'd9, 5'd14, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 2'd2};
        tbl[5]  = '{1'b1, 5'd0,  5'd0, 5'd7,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0};
        tbl[6]  = '{1'b1, 5'd1,  5'd2, 5'd20, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0};
        tbl[7]  = '{1'b1, 5'd0,  5'd0, 5'd7,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0};
        tbl[8]  = '{1'b1, 5'd3,  5'd7, 5'd21, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd1};
        tbl[9]  = '{1'b1, 5'd1,  5'd2, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0};
        tbl[10] = '{1'b1, 5'd0,  5'd0, 5'd22, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0};
        tbl[11] = '{1'b1, 5'd1,  5'd2, 5'd3,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0};
        tbl[12] = '{1'b1, 5'd3,  5'd4, 5'd23, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        tbl[13] = '{1'b1, 5'd3,  5'd4, 5'd23, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 2'd0};
        tbl[14] = '{1'b0, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0};
        tbl[15] = '{1'b1, 5'd1,  5'd2, 5'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0};
        tbl[16] = '{1'b1, 5'd0,  5'd0, 5'd24, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0};
        tbl[17] = '{1'b1, 5'd1,  5'd2, 5'd3,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0};
        tbl[18] = '{1'b1, 5'd3,  5'd0, 5'd3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        tbl[19] = '{1'b1, 5'd3,  5'd0, 5'd3,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 2'd0};
        tbl[20] = '{1'b1, 5'd3,  5'd3, 5'd25, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        tbl[21] = '{1'b1, 5'd3,  5'd3, 5'd25, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 2'd2};
        tbl[22] = '{1'b1, 5'd25, 5'd0, 5'd26, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0};
        tbl[23] = '{1'b1, 5'd0,  5'd0, 5'd3,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0};
        tbl[24] = '{1'b1, 5'd3,  5'd1, 5'd26, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0};
        tbl[25] = '{1'b0, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0};
        tbl[26] = '{1'b1, 5'd3,  5'd1, 5'd26, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 2'd0};

        // Reset state
        model_reset();
        #12;
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_sel", {30'd0, sel_a | sel_b}, 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_id_ready", 32'(id_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            run_cycle(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].wr, tbl[i].ld,
                      tbl[i].fl, 1'b1, tbl[i].e_rdy, tbl[i].e_exv, tbl[i].e_sa, tbl[i].e_sb);
        end
        // Three unflushed load-use stalls occurred above
        chk("loaduse_cnt", 32'(stall_cnt), PERF ? 32'd3 : 32'd0);

        // Reset asserted in the middle of a load-use stall
        run_cycle(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        @(negedge clk);
        id_valid = 1'b1; id_rs1 = 5'd3; id_rs2 = 5'd0; id_rd = 5'd4;
        id_reg_write = 1'b1; id_is_load = 1'b0; flush = 1'b0;
        #1;
        chk("midrst_stalled", 32'(id_ready), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_ex_valid", 32'(ex_valid), 32'd0);
        chk("midrst_sel", {28'd0, sel_a, sel_b}, 32'd0);
        chk("midrst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("midrst_id_ready", 32'(id_ready), 32'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_cycle(1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0);

        // Twenty load-use stalls: narrow counter must saturate
        for (int i = 0; i < 20; i++) begin
            run_cycle(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
            run_cycle(1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
            run_cycle(1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 2'd0);
        end
        chk("sat_cnt_w4", 32'(stall_cnt4), PERF ? 32'd15 : 32'd0);
        chk("sat_cnt_w16", 32'(stall_cnt), PERF ? 32'd20 : 32'd0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            run_cycle(1'(($urandom % 5) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 1'(($urandom % 4) != 0), 1'(($urandom % 3) == 0),
                      1'(($urandom % 10) == 0), 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
